// File: rtl/multi_pulse_det_pkg.sv
// Shared mode encodings and per-channel FSM state type for the multi-channel pulse detector.
package multi_pulse_det_pkg;

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_HIGH = 2'b10;
   localparam logic [1:0] MODE_LOW  = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

endpackage

// File: rtl/pulse_det_chan.sv
// One detector channel: glitch filter, edge/pulse FSM, saturating width counter and sticky overflow.
//
// state | meaning
// IDLE  | waiting for a filtered edge; edge modes strobe here, pulse modes look for the start edge
// MEAS  | pulse in progress; width counter running until the opposite filtered edge
module pulse_det_chan
   import multi_pulse_det_pkg::*;
#(
   parameter int FILT  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             clr_ovf,
   input  logic             c,
   output logic             y,
   output logic [CNT_W-1:0] width,
   output logic             ovf
);

   localparam int               FW      = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [FW-1:0]    FILT_LD = FW'(FILT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             f_q, f_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] width_q, width_d;
   logic             y_q, y_d;
   logic             ovf_q, ovf_d;
   logic             fe, fe_rise, fe_fall, end_fe;

   // Filter counts down the cycles still needed before f may follow c.
   always_comb begin
      f_d    = f_q;
      fcnt_d = fcnt_q;
      fe     = 1'b0;
      if (c == f_q) begin
         fcnt_d = FILT_LD;
      end else if (fcnt_q == '0) begin
         f_d    = c;
         fcnt_d = FILT_LD;
         fe     = 1'b1;
      end else begin
         fcnt_d = fcnt_q - 1'b1;
      end
      fe_rise = fe & c;
      fe_fall = fe & ~c;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      width_d = width_q;
      y_d     = 1'b0;
      ovf_d   = ovf_q;
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end_fe  = (mode_q == MODE_LOW) ? fe_rise : fe_fall;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         if (clr_ovf) ovf_d = 1'b0;
         case (state_q)
            IDLE: begin
               case (mode)
                  MODE_RISE: y_d = fe_rise;
                  MODE_FALL: y_d = fe_fall;
                  MODE_HIGH: begin
                     if (fe_rise) begin
                        state_d = MEAS;
                        cnt_d   = CNT_W'(1);
                        mode_d  = mode;
                     end
                  end
                  MODE_LOW: begin
                     if (fe_fall) begin
                        state_d = MEAS;
                        cnt_d   = CNT_W'(1);
                        mode_d  = mode;
                     end
                  end
               endcase
            end
            MEAS: begin
               if (end_fe) begin
                  y_d     = 1'b1;
                  width_d = cnt_q;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
                  // Holding at saturation keeps re-asserting, so a clear mid-pulse loses.
                  if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f_q     <= 1'b0;
         fcnt_q  <= FILT_LD;
         state_q <= IDLE;
         mode_q  <= MODE_RISE;
         cnt_q   <= '0;
         width_q <= '0;
         y_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         f_q     <= f_d;
         fcnt_q  <= fcnt_d;
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         width_q <= width_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
      end
   end

   assign y     = y_q;
   assign width = width_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/multi_pulse_det.sv
// Multi-channel edge/pulse detector: slices the buses and fans shared controls out to each channel.
module multi_pulse_det
   import multi_pulse_det_pkg::*;
#(
   parameter int CH    = 4,
   parameter int FILT  = 2,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                clr_ovf,
   input  logic [CH-1:0]       C,
   output logic [CH-1:0]       Y,
   output logic [CH*CNT_W-1:0] width_o,
   output logic [CH-1:0]       ovf
);

   for (genvar i = 0; i < CH; i++) begin : g_chan
      pulse_det_chan #(
         .FILT  (FILT),
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .mode    (mode),
         .clr_ovf (clr_ovf),
         .c       (C[i]),
         .y       (Y[i]),
         .width   (width_o[i*CNT_W +: CNT_W]),
         .ovf     (ovf[i])
      );
   end

endmodule
